// File: rtl/exe_hazard_ctrl_if.sv
// Interface bundling the ID-stage instruction info, the EXE/MEM status
// inputs and the hazard-control outputs of exe_hazard_ctrl.
// master: pipeline side that drives ID info and observes the controls.
// slave : the hazard controller itself.
interface exe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic             id_wb_en;
    logic             id_mem_r;
    logic [3:0]       id_dest;
    logic             exe_branch_taken;
    logic             mem_busy;

    logic [1:0]       sel1;
    logic [1:0]       sel2;
    logic             freeze_if_id;
    logic             bubble_id_exe;
    logic             flush;
    logic             freeze_all;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
               id_wb_en, id_mem_r, id_dest, exe_branch_taken, mem_busy,
        input  sel1, sel2, freeze_if_id, bubble_id_exe, flush, freeze_all,
               stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
               id_wb_en, id_mem_r, id_dest, exe_branch_taken, mem_busy,
        output sel1, sel2, freeze_if_id, bubble_id_exe, flush, freeze_all,
               stall_cnt
    );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard controller for the 5-stage pipeline.
// Tracks destination/write-back info of the instructions in EXE and MEM,
// generates registered operand-forwarding selects and the stall, bubble,
// flush and global-freeze controls.
// Build option: define FWD_EN to compile in operand forwarding. Without it
// the selects stay 0 and every RAW hazard on EXE or MEM stalls instead.
module exe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    exe_hazard_ctrl_if.slave bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Tracking of the instruction resident in EXE
    logic             r_exe_v;
    logic             r_exe_wb;
    logic             r_exe_mr;
    logic [3:0]       r_exe_dst;
    // Tracking of the instruction resident in MEM
    logic             r_mem_v;
    logic             r_mem_wb;
    logic [3:0]       r_mem_dst;

    logic [1:0]       r_sel1;
    logic [1:0]       r_sel2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_exe_m1;
    logic             w_exe_m2;
    logic             w_mem_m1;
    logic             w_mem_m2;
    logic             w_hazard;
    logic [1:0]       w_sel1_next;
    logic [1:0]       w_sel2_next;

    logic             w_freeze_all;
    logic             w_flush;
    logic             w_stall;

    // A producer matches only if it is a real instruction that writes back
    assign w_exe_m1 = r_exe_v & r_exe_wb & (r_exe_dst == bus.id_src1);
    assign w_exe_m2 = r_exe_v & r_exe_wb & (r_exe_dst == bus.id_src2);
    assign w_mem_m1 = r_mem_v & r_mem_wb & (r_mem_dst == bus.id_src1);
    assign w_mem_m2 = r_mem_v & r_mem_wb & (r_mem_dst == bus.id_src2);

`ifdef FWD_EN
    // Newest producer wins: EXE (sel=1) before MEM (sel=2)
    function automatic logic [1:0] fwd_sel(input logic use_src,
                                           input logic m_exe,
                                           input logic m_mem);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src & m_exe)
            sel = 2'd1;
        else if (use_src & m_mem)
            sel = 2'd2;
        return sel;
    endfunction

    // Only a load in EXE cannot be forwarded in time: one-cycle load-use stall
    assign w_hazard = bus.id_valid & r_exe_mr &
                      ((bus.id_use_src1 & w_exe_m1) | (bus.id_use_src2 & w_exe_m2));
    assign w_sel1_next = fwd_sel(bus.id_use_src1, w_exe_m1, w_mem_m1);
    assign w_sel2_next = fwd_sel(bus.id_use_src2, w_exe_m2, w_mem_m2);
`else
    // No forwarding: any RAW on an in-flight producer stalls until it retires
    assign w_hazard = bus.id_valid &
                      ((bus.id_use_src1 & (w_exe_m1 | w_mem_m1)) |
                       (bus.id_use_src2 & (w_exe_m2 | w_mem_m2)));
    assign w_sel1_next = 2'd0;
    assign w_sel2_next = 2'd0;

    // Load flag is only needed for forwarding; keep it tracked but unread
    logic w_unused_exe_mr;
    assign w_unused_exe_mr = r_exe_mr;
`endif

    // State register: records whether the pipeline is held by memory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: WAIT lasts exactly as long as mem_busy is high
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_next = ST_RUN;
        case (r_state)
            ST_RUN:  w_state_next = bus.mem_busy ? ST_WAIT : ST_RUN;
            ST_WAIT: w_state_next = bus.mem_busy ? ST_WAIT : ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    // Output logic: mem_busy overrides flush, flush overrides the stall
    always_comb begin
        w_freeze_all = bus.mem_busy;
        w_flush      = r_exe_v & bus.exe_branch_taken & ~bus.mem_busy;
        w_stall      = w_hazard & ~w_flush & ~bus.mem_busy;
    end

    assign bus.freeze_all    = w_freeze_all;
    assign bus.flush         = w_flush;
    assign bus.freeze_if_id  = w_stall;
    assign bus.bubble_id_exe = w_stall;
    assign bus.sel1          = r_sel1;
    assign bus.sel2          = r_sel2;
    assign bus.stall_cnt     = r_stall_cnt;

    // Pipeline tracking and forwarding selects; everything holds while frozen
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all tracking state is cleared by the asynchronous reset so a
        // reset during a memory wait leaves no stale producer behind.
        if (!rst) begin
            r_exe_v   <= 1'b0;
            r_exe_wb  <= 1'b0;
            r_exe_mr  <= 1'b0;
            r_exe_dst <= 4'd0;
            r_mem_v   <= 1'b0;
            r_mem_wb  <= 1'b0;
            r_mem_dst <= 4'd0;
            r_sel1    <= 2'd0;
            r_sel2    <= 2'd0;
        end else if (!w_freeze_all) begin
            // NOTE: non-blocking assignments let MEM take the old EXE contents
            // in the same edge that EXE is overwritten.
            r_mem_v   <= r_exe_v;
            r_mem_wb  <= r_exe_wb;
            r_mem_dst <= r_exe_dst;
            if (w_flush | w_stall) begin
                r_exe_v   <= 1'b0;
                r_exe_wb  <= 1'b0;
                r_exe_mr  <= 1'b0;
                r_exe_dst <= 4'd0;
                r_sel1    <= 2'd0;
                r_sel2    <= 2'd0;
            end else begin
                r_exe_v   <= bus.id_valid;
                r_exe_wb  <= bus.id_wb_en & bus.id_valid;
                r_exe_mr  <= bus.id_mem_r & bus.id_valid;
                r_exe_dst <= bus.id_dest;
                r_sel1    <= w_sel1_next;
                r_sel2    <= w_sel2_next;
            end
        end
    end

    // Saturating count of cycles spent with IF/ID frozen by a hazard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

endmodule

// File: doc/exe_hazard_ctrl.md
Name: exe_hazard_ctrl

Overview:
- Sequences the EXE-stage operand datapath of the 5-stage pipeline.
- Tracks destination and write-back info of instructions entering the EXE and MEM stages.
- Produces registered forwarding selects (sel1/sel2) for the EXE operand muxes.
- Produces stall, bubble and flush controls for load-use hazards, taken branches and memory wait states.

Parameters:
CNT_W, 16, width of the saturating hazard-stall counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  4  Rn index of ID instruction
id_src2  in  4  Rm/Rd source index of ID instruction
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
id_wb_en  in  1  ID instruction writes a register
id_mem_r  in  1  ID instruction is a load
id_dest  in  4  destination index of ID instruction
exe_branch_taken  in  1  EXE instruction is a taken branch
mem_busy  in  1  memory stage not ready; whole pipeline must hold
sel1  out  2  EXE src1 mux select: 0 regfile, 1 MEM, 2 WB
sel2  out  2  EXE src2 mux select, same encoding
freeze_if_id  out  1  hold PC and IF/ID register
bubble_id_exe  out  1  ID/EXE register loads NOP this edge
flush  out  1  IF/ID and ID/EXE load NOP this edge
freeze_all  out  1  all pipeline registers hold
stall_cnt  out  CNT_W  cycles with freeze_if_id=1, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - Tracking registers cleared: exe_v, exe_wb, exe_mr, exe_dst, mem_v, mem_wb, mem_dst = 0.
  - sel1 = sel2 = 0, stall_cnt = 0, state = RUN.
  - Combinational outputs evaluate with all tracking invalid.
- match(stage, s) = stage_v & stage_wb & (stage_dst == s).
- State machine:
  - RUN: normal operation.
  - WAIT: entered on any edge where mem_busy=1; left on the first edge where mem_busy=0.
  - State is visible only through stall_cnt hold and a debug-free register. No output depends on the state beyond what is listed below.
- freeze_all = mem_busy, combinational.
  - While freeze_all=1: every tracking register, sel1/sel2 and stall_cnt hold.
  - flush, freeze_if_id and bubble_id_exe are forced to 0.
- flush = exe_v & exe_branch_taken & ~mem_busy.
  - Edge action: MEM tracking takes EXE contents; EXE tracking loads invalid; sel1/sel2 load 0.
- Load-use (priority below flush):
  - lu = id_valid & exe_mr & ((id_use_src1 & match(exe, id_src1)) | (id_use_src2 & match(exe, id_src2))).
  - freeze_if_id = bubble_id_exe = lu & ~flush & ~mem_busy.
  - Edge action: EXE tracking loads invalid; MEM tracking takes EXE; sel loads 0.
  - Exactly one stall cycle per load-use. On the next cycle the producer sits in MEM and forwarding resolves via sel=2.
- Normal advance (no freeze_all, flush or lu):
  - MEM tracking takes EXE tracking.
  - EXE tracking takes {id_valid, id_wb_en & id_valid, id_mem_r & id_valid, id_dest}.
  - sel1 loads 1 if id_use_src1 & match(exe, id_src1); else 2 if id_use_src1 & match(mem, id_src1); else 0. Newest producer wins.
  - sel2 is computed the same way using id_src2 / id_use_src2.
- sel1/sel2 are registered and apply to the instruction resident in EXE for its entire EXE residency, including freeze_all cycles.
- Sources with use=0, producers with wb_en=0, and bubbles never match.
- stall_cnt increments on each edge where freeze_if_id=1 and saturates at all-ones.
- Simultaneous events:
  - mem_busy overrides flush and lu.
  - flush overrides lu.
  - Reset overrides everything at any time, including mid-WAIT.

Optional Feature:
- Macro FWD_EN, compiled in:
  - Forwarding behaves as above.
- Macro FWD_EN, compiled out:
  - sel1 = sel2 = 0 constantly.
  - The lu term is replaced by any RAW hazard: id_valid & (source matches exe or mem, wb_en set, regardless of load).
  - The replacement term drives freeze_if_id and bubble_id_exe with the same priority rules. stall_cnt counts these stalls.

Test Plan:
- Reset mid-WAIT (mem_busy=1, exe_v=1): assert rst=0 → immediately sel=0, stall_cnt=0, all tracking invalid; after release with mem_busy=0 → freeze_all=0.
- ADD R1 then SUB R2,R1,R3 back-to-back → SUB in EXE with sel1=1, sel2=0, no freeze. With one NOP between → sel1=2.
- LDR R4 then ADD R5,R4,R4 → one cycle freeze_if_id=bubble_id_exe=1, stall_cnt=1; ADD then enters EXE with sel1=sel2=2.
- Taken branch in EXE while ID holds LDR-dependent instruction → flush=1, freeze_if_id=0; next cycle exe_v=0, sel=0.
- mem_busy=1 for 3 cycles with ADD in EXE (sel1=1) → freeze_all=1 for 3 cycles; sel1 stays 1; stall_cnt unchanged.
- FWD_EN off: ADD R1; SUB R2,R1,R3 → two stall cycles (stall_cnt=2), sel always 0.
